// File: rtl/result_accumulator.sv
// Frame accumulator: sums N_SAMPLES signed results with per-sample saturation,
// counts V-flag events, and holds the frame total on a valid/ready port until taken.
module result_accumulator #(
  parameter int N_SAMPLES = 16,
  parameter int ACC_W     = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [5:0]       Result,
  input  logic [3:0]              Flags,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] AccOut,
  output logic [3:0]              OvfCount,
  output logic                    SatFlag,
  output logic [7:0]              SampleCnt
);

  typedef enum logic {ST_ACCUM = 1'b0, ST_DONE = 1'b1} state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic                    r_run;
  logic signed [ACC_W-1:0] r_acc;
  logic [3:0]              r_ovf;
  logic                    r_sat;
  logic [7:0]              r_cnt;
  logic [2:0]              r_dbg_flags;

  logic                    w_xfer;
  logic                    w_last;
  logic                    w_take;
  logic signed [ACC_W:0]   w_sum;
  logic                    w_pos_clip;
  logic                    w_neg_clip;
  logic signed [ACC_W-1:0] w_acc_nxt;

  assign w_xfer = in_valid && in_ready;
  assign w_take = out_valid && out_ready;
  assign w_last = (r_cnt == 8'(N_SAMPLES - 1));

  // One guard bit is enough: a 6-bit addend cannot overflow ACC_W+1 bits.
  assign w_sum      = {r_acc[ACC_W-1], r_acc} + {{(ACC_W-5){Result[5]}}, Result};
  assign w_pos_clip = !w_sum[ACC_W] &&  w_sum[ACC_W-1];
  assign w_neg_clip =  w_sum[ACC_W] && !w_sum[ACC_W-1];

  always_comb begin
    w_acc_nxt = w_sum[ACC_W-1:0];
    if (w_pos_clip) w_acc_nxt = {1'b0, {(ACC_W-1){1'b1}}};
    if (w_neg_clip) w_acc_nxt = {1'b1, {(ACC_W-1){1'b0}}};
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      ST_ACCUM: begin
        in_ready = r_run;
        if (w_xfer && w_last) w_next = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = ST_ACCUM;
      end
      default: w_next = ST_ACCUM;
    endcase
    if (clear) w_next = ST_ACCUM;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_ACCUM;
      r_run   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_run   <= 1'b1;
    end
  end

  // Clear and the frame handshake both restart the frame; clear also drops any same-cycle transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc       <= '0;
      r_ovf       <= '0;
      r_sat       <= 1'b0;
      r_cnt       <= '0;
      r_dbg_flags <= '0;
    end else if (clear || w_take) begin
      r_acc <= '0;
      r_ovf <= '0;
      r_sat <= 1'b0;
      r_cnt <= '0;
    end else if (w_xfer) begin
      r_acc       <= w_acc_nxt;
      r_cnt       <= r_cnt + 8'd1;
      r_dbg_flags <= Flags[3:1];
      if (Flags[0] && (r_ovf != 4'hF)) r_ovf <= r_ovf + 4'd1;
      if (w_pos_clip || w_neg_clip) r_sat <= 1'b1;
    end
  end

  assign AccOut    = r_acc;
  assign OvfCount  = r_ovf;
  assign SatFlag   = r_sat;
  assign SampleCnt = r_cnt;

endmodule

// File: tb/tb_result_accumulator.sv
// Scoreboarded bench for result_accumulator: a behavioural model queues each
// expected frame total, and a monitor pops and compares on every output handshake.
module tb_result_accumulator;

  localparam int N = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              clear;
  logic              in_valid;
  logic              in_ready;
  logic signed [5:0] Result;
  logic [3:0]        Flags;
  logic              out_valid;
  logic              out_ready;
  logic signed [7:0] AccOut;
  logic [3:0]        OvfCount;
  logic              SatFlag;
  logic [7:0]        SampleCnt;

  result_accumulator #(.N_SAMPLES(N), .ACC_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .Result(Result), .Flags(Flags), .out_valid(out_valid), .out_ready(out_ready),
    .AccOut(AccOut), .OvfCount(OvfCount), .SatFlag(SatFlag), .SampleCnt(SampleCnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int acc;
    int ovf;
    int sat;
  } frame_t;

  frame_t sb[$];
  int n_checks = 0;
  int n_pass   = 0;
  int n_frames = 0;
  int m_acc, m_ovf, m_sat, m_cnt;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic model_reset();
    m_acc = 0; m_ovf = 0; m_sat = 0; m_cnt = 0;
  endtask

  // Drive one transfer (caller guarantees ACCUM), then check the post-edge accumulator.
  task automatic send(input int r, input logic [3:0] f);
    frame_t fr;
    int s;
    in_valid = 1'b1;
    Result   = 6'(r);
    Flags    = f;
    @(negedge clk);
    chk("in_ready", int'(in_ready), 1);
    @(posedge clk);
    s = m_acc + r;
    if (s > 127)  begin s = 127;  m_sat = 1; end
    if (s < -128) begin s = -128; m_sat = 1; end
    m_acc = s;
    if (f[0] && m_ovf < 15) m_ovf++;
    m_cnt++;
    #1;
    in_valid = 1'b0;
    chk("acc_step", int'(AccOut), m_acc);
    if (m_cnt == N) begin
      fr.acc = m_acc; fr.ovf = m_ovf; fr.sat = m_sat;
      sb.push_back(fr);
      model_reset();
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every output handshake must match the oldest queued frame.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      n_frames++;
      if (sb.size() == 0) begin
        chk("unexpected_frame", 1, 0);
      end else begin
        frame_t e;
        e = sb.pop_front();
        chk("frame_acc", int'(AccOut), e.acc);
        chk("frame_ovf", int'(OvfCount), e.ovf);
        chk("frame_sat", int'(SatFlag), e.sat);
        chk("frame_cnt", int'(SampleCnt), N);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  int frozen;

  initial begin
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    Result = '0; Flags = '0;
    model_reset();
    #12;
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_acc", int'(AccOut), 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    chk("rel_in_ready", int'(in_ready), 1);

    // Mid-frame asynchronous reset.
    for (int i = 0; i < 5; i++) send(3, 4'b0001);
    chk("pre_rst_cnt", int'(SampleCnt), 5);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_acc", int'(AccOut), 0);
    chk("arst_cnt", int'(SampleCnt), 0);
    chk("arst_ovf", int'(OvfCount), 0);
    chk("arst_in_ready", int'(in_ready), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    chk("rearm_in_ready", int'(in_ready), 1);
    chk("rearm_cnt", int'(SampleCnt), 0);

    // Basic frame: out_valid for exactly one cycle, then cleared.
    for (int i = 0; i < N; i++) send(1, 4'b0000);
    chk("basic_out_valid", int'(out_valid), 1);
    chk("basic_in_ready", int'(in_ready), 0);
    idle(1);
    chk("basic_valid_drop", int'(out_valid), 0);
    chk("basic_acc_zero", int'(AccOut), 0);

    // Saturation: positive, negative, and mixed (recovers from the clipped value).
    for (int i = 0; i < N; i++) send(31, 4'b0000);
    idle(1);
    for (int i = 0; i < N; i++) send(-32, 4'b0000);
    idle(1);
    for (int i = 0; i < 5; i++) send(31, 4'b0000);
    for (int i = 0; i < 11; i++) send(-32, 4'b0000);
    idle(1);

    // Overflow counting: saturating at 15, and sparse V on samples 2, 7, 9.
    for (int i = 0; i < N; i++) send(0, 4'b0001);
    idle(1);
    for (int i = 1; i <= N; i++) send(i - 8, (i == 2 || i == 7 || i == 9) ? 4'b1001 : 4'b0110);
    idle(1);

    // Backpressure: hold DONE for 6 cycles while upstream keeps offering a sample.
    out_ready = 1'b0;
    for (int i = 0; i < N; i++) send(-5, 4'b0000);
    frozen = int'(AccOut);
    in_valid = 1'b1; Result = 6'sd5; Flags = 4'b0000;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("bp_in_ready", int'(in_ready), 0);
      chk("bp_acc_frozen", int'(AccOut), frozen);
      chk("bp_cnt_frozen", int'(SampleCnt), N);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    idle(1);
    send(5, 4'b0000);
    chk("bp_resume_cnt", int'(SampleCnt), 1);
    for (int i = 1; i < N; i++) send(2, 4'b0000);
    idle(1);

    // Clear with a concurrent transfer drops that transfer.
    for (int i = 0; i < 3; i++) send(4, 4'b0001);
    in_valid = 1'b1; Result = 6'sd10; clear = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; clear = 1'b0;
    chk("clr_acc", int'(AccOut), 0);
    chk("clr_cnt", int'(SampleCnt), 0);
    chk("clr_ovf", int'(OvfCount), 0);
    model_reset();

    // Clear in DONE aborts the frame without a handshake.
    out_ready = 1'b0;
    for (int i = 0; i < N; i++) send(7, 4'b0000);
    chk("done_out_valid", int'(out_valid), 1);
    void'(sb.pop_back());
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    chk("clrdone_out_valid", int'(out_valid), 0);
    chk("clrdone_in_ready", int'(in_ready), 1);
    chk("clrdone_acc", int'(AccOut), 0);
    out_ready = 1'b1;
    send(9, 4'b0000);
    chk("post_clr_cnt", int'(SampleCnt), 1);
    idle(2);

    chk("sb_drained", sb.size(), 0);
    chk("frames_seen", n_frames, 8);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
